// File: rtl/i2c_slave_rx.sv
// Write-only I2C target: oversampled, glitch-filtered SCL/SDA, 7-bit address match,
// ACKs address and every data byte, presents each byte with a one-cycle strobe.
module i2c_slave_rx #(
    parameter logic [6:0]  SLAVE_ADDR = 7'h5A,
    parameter int unsigned FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  wire        sda,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       busy,
    output logic       stop_det
);

    localparam logic [2:0] FiltMax = 3'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAddrAck,
        StData,
        StDataAck,
        StIgnore
    } state_e;

    logic       scl_s1, scl_s2, sda_s1, sda_s2;
    logic       scl_f, sda_f, scl_f_prev, sda_f_prev;
    logic [2:0] scl_cnt, sda_cnt;

    state_e     state_q;
    logic [6:0] shift_q;
    logic [2:0] bit_cnt_q;
    logic       sda_low_q;

    logic scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_cond, stop_cond;

    // Synchronizers and per-line glitch filters; idle bus level is 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_s1     <= 1'b1;
            scl_s2     <= 1'b1;
            sda_s1     <= 1'b1;
            sda_s2     <= 1'b1;
            scl_f      <= 1'b1;
            sda_f      <= 1'b1;
            scl_f_prev <= 1'b1;
            sda_f_prev <= 1'b1;
            scl_cnt    <= 3'd0;
            sda_cnt    <= 3'd0;
        end else begin
            scl_s1     <= scl;
            scl_s2     <= scl_s1;
            sda_s1     <= sda;
            sda_s2     <= sda_s1;
            scl_f_prev <= scl_f;
            sda_f_prev <= sda_f;

            if (scl_s2 != scl_f) begin
                if (scl_cnt == FiltMax) begin
                    scl_f   <= scl_s2;
                    scl_cnt <= 3'd0;
                end else begin
                    scl_cnt <= scl_cnt + 3'd1;
                end
            end else begin
                scl_cnt <= 3'd0;
            end

            if (sda_s2 != sda_f) begin
                if (sda_cnt == FiltMax) begin
                    sda_f   <= sda_s2;
                    sda_cnt <= 3'd0;
                end else begin
                    sda_cnt <= sda_cnt + 3'd1;
                end
            end else begin
                sda_cnt <= 3'd0;
            end
        end
    end

    always_comb begin
        scl_rise   = scl_f & ~scl_f_prev;
        scl_fall   = ~scl_f & scl_f_prev;
        sda_rise   = sda_f & ~sda_f_prev;
        sda_fall   = ~sda_f & sda_f_prev;
        // SCL must have been high on both sides of the SDA edge.
        start_cond = sda_fall & scl_f & scl_f_prev;
        stop_cond  = sda_rise & scl_f & scl_f_prev;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            shift_q    <= 7'd0;
            bit_cnt_q  <= 3'd0;
            sda_low_q  <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            stop_det   <= 1'b0;
            if (stop_cond) begin
                state_q   <= StIdle;
                bit_cnt_q <= 3'd0;
                sda_low_q <= 1'b0;
                busy      <= 1'b0;
                stop_det  <= 1'b1;
            end else if (start_cond) begin
                state_q   <= StAddr;
                bit_cnt_q <= 3'd0;
                sda_low_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StAddr: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[5:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (shift_q == SLAVE_ADDR && !sda_f) begin
                                    state_q <= StAddrAck;
                                end else begin
                                    state_q <= StIgnore;
                                    busy    <= 1'b0;
                                end
                            end
                        end
                    end
                    StAddrAck, StDataAck: begin
                        // First fall starts the ACK bit, second fall ends it.
                        if (scl_fall) begin
                            if (!sda_low_q) begin
                                sda_low_q <= 1'b1;
                                busy      <= 1'b1;
                            end else begin
                                sda_low_q <= 1'b0;
                                bit_cnt_q <= 3'd0;
                                state_q   <= StData;
                            end
                        end
                    end
                    StData: begin
                        if (scl_rise) begin
                            shift_q   <= {shift_q[5:0], sda_f};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                data_out   <= {shift_q, sda_f};
                                data_valid <= 1'b1;
                                state_q    <= StDataAck;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: doc/i2c_slave_rx.md
Name: i2c_slave_rx

Overview:
Write-only I2C target (slave) receiver that sits on the same SDA/SCL bus as i2c_master and consumes what it produces. It oversamples SCL/SDA with the system clock, detects START/STOP, matches a 7-bit address and ACKs it. It then shifts in data bytes, ACKs each one, and presents each byte on a parallel output with a one-cycle valid strobe. It never stretches SCL and never transmits data.

Parameters:
SLAVE_ADDR, 7'h5A, 7-bit address this target responds to.
FILTER_LEN, 3, consecutive identical synchronized samples required before a bus level change is accepted (1..7).

Ports:
clk  input  1  system clock; the only clock.
reset  input  1  asynchronous, active-low reset.
scl  input  1  I2C clock (externally pulled up).
sda  inout  1  I2C data, open-drain: driven 0 or released to 'z', never driven 1.
data_out  output  8  last received data byte, MSB first on the bus.
data_valid  output  1  one-clk pulse when data_out is updated.
busy  output  1  high from an accepted address until STOP or a NACKed address.
stop_det  output  1  one-clk pulse on every detected STOP.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE, sda released, data_out=8'h00, data_valid=0, busy=0, stop_det=0, bit counter=0, filters preset to 1.
- Input path: 2-flop synchronizer on scl and sda, then a per-line glitch filter. The filtered level changes only after FILTER_LEN equal consecutive samples. Edge flags are derived from the filtered levels.
- START: filtered SDA falls while filtered SCL=1. It is accepted in any state, including as a repeated START. Action: go to ADDR, clear the bit counter, release sda.
- STOP: filtered SDA rises while filtered SCL=1. It is accepted in any state. Action: go to IDLE, release sda, busy=0, stop_det pulses for 1 clk.
- Bits are sampled on the filtered SCL rising edge into an 8-bit shift register, MSB first. A 3-bit counter counts 0..7.
- States and transitions:
  - IDLE: ignore SCL and wait for START.
  - ADDR: shift 8 bits. After the 8th rising edge, compare {shift[7:1]} to SLAVE_ADDR and check R/W=shift[0].
    - Match with R/W=0: go to ADDR_ACK.
    - Anything else: go to IGNORE and leave sda released (NACK).
  - ADDR_ACK: on the next SCL falling edge drive sda=0 and set busy=1. On the following falling edge release sda, clear the counter and go to DATA.
  - DATA: shift 8 bits. On the 8th rising edge load data_out and pulse data_valid, then go to DATA_ACK.
  - DATA_ACK: identical timing to ADDR_ACK (drive sda low for one SCL low-high-low period), then return to DATA for the next byte.
  - IGNORE: stay until START or STOP.
- data_valid latency: 1 clk after the filtered SCL rising edge of bit 8, i.e. 2+FILTER_LEN+1 clk after the raw SCL edge.
- Every byte that reaches bit 8 is ACKed; no flow control and no NACK on data.
- SDA changing while SCL is high is always interpreted as START or STOP, never as data.
- A START or STOP mid-byte discards the partial byte. data_out is not updated and data_valid does not pulse.
- A START or STOP during an ACK slot releases sda in the same clk the condition is detected.
- Counter wrap: after bit 8 the counter returns to 0; there is no byte limit per transaction.
- An SCL rising edge in IDLE or IGNORE has no effect.
- Reset asserted mid-transfer releases sda immediately (asynchronous). After reset release the block waits for a fresh START.

Test Plan:
- Reset: hold reset=0 mid-bus-activity -> sda='z', data_out=8'h00, busy=0, data_valid=0, stop_det=0.
- Write 1 byte: START, addr byte 8'hB4, data 8'h3C, STOP (bus bit period 6 clk) -> sda=0 during both 9th clocks, data_out=8'h3C with one data_valid pulse, busy high between the address ACK and STOP, stop_det pulses once.
- Read request: START, 8'hB5, STOP -> sda stays 'z' through the 9th clock, no data_valid, busy stays 0, stop_det pulses.
- Wrong address: START, 8'h42, 8'hFF, STOP -> no ACK, no data_valid; a following START, 8'hB4, 8'hA5 gives data_out=8'hA5.
- Multi-byte with repeated START: START, 8'hB4, 8'h11, 8'h22, a repeated START aborting after 4 bits of 8'h33, then 8'hB4, 8'h44, STOP -> data_valid exactly 3 times, with data_out 8'h11, then 8'h22, then 8'h44.
- Glitch: 1-clk low pulse on SDA while SCL is high, in IDLE and in DATA -> no START/STOP detected, no state change, byte completes correctly.
